sata_crc_inserter: RTL and testbench

SATA_CRC_INSERTER -- requirements
Module: sata_crc_inserter

---
 rtl/sata_crc_inserter_pkg.sv | 7 +
 rtl/sata_crc32_step.sv | 23 ++
 rtl/sata_crc_inserter.sv | 73 +++++++
 tb/tb_sata_crc_inserter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sata_crc_inserter_pkg.sv
// Shared SATA CRC constants for the transmit-side inserter and receive-side checker.
package sata_crc_inserter_pkg;

  localparam logic [31:0] SATA_CRC_POLYNOMIAL = 32'h04C11DB7;
  localparam logic [31:0] SATA_CRC_INITVALUE  = 32'h52325032;

endpackage

// File: rtl/sata_crc32_step.sv
// One-dword CRC-32 advance: MSB first, no reflection, no final XOR.
module sata_crc32_step
  import sata_crc_inserter_pkg::*;
#(
  parameter logic [31:0] POLY = SATA_CRC_POLYNOMIAL
) (
  input  logic [31:0] i_crc,
  input  logic [31:0] i_dat,
  output logic [31:0] o_crc
);

  logic [31:0] c;

  // Folding the dword into the register up front equals 32 serial bit steps.
  always_comb begin
    c = i_crc ^ i_dat;
    for (int b = 0; b < 32; b++) begin
      c = c[31] ? ({c[30:0], 1'b0} ^ POLY) : {c[30:0], 1'b0};
    end
    o_crc = c;
  end

endmodule

// File: rtl/sata_crc_inserter.sv
// Passes frame payload through one register stage and appends the frame CRC dword.
module sata_crc_inserter
  import sata_crc_inserter_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = SATA_CRC_INITVALUE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_dat,
  input  logic        i_val,
  input  logic        i_eop,
  output logic        i_rdy,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_eop,
  input  logic        o_rdy
);

  typedef enum logic {DATA, CRC} state_t;

  state_t      state, state_nxt;
  logic [31:0] crc, crc_step;
  logic        out_free, take;

  assign out_free = !o_val || o_rdy;
  assign i_rdy    = (state == DATA) && out_free;
  assign take     = i_val && i_rdy;

  sata_crc32_step #(.POLY(SATA_CRC_POLYNOMIAL)) u_step (
    .i_crc(crc),
    .i_dat(i_dat),
    .o_crc(crc_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= DATA;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DATA: if (take && i_eop) state_nxt = CRC;
      CRC:  if (out_free)      state_nxt = DATA;
      default:                 state_nxt = DATA;
    endcase
  end

  // CRC beat drains the register and reseeds it, so the next frame starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc   <= CRC_INIT;
      o_dat <= '0;
      o_val <= 1'b0;
      o_eop <= 1'b0;
    end else if (out_free) begin
      if (state == CRC) begin
        o_dat <= crc;
        o_val <= 1'b1;
        o_eop <= 1'b1;
        crc   <= CRC_INIT;
      end else if (take) begin
        o_dat <= i_dat;
        o_val <= 1'b1;
        o_eop <= 1'b0;
        crc   <= crc_step;
      end else begin
        o_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sata_crc_inserter.sv
// Scoreboard bench for sata_crc_inserter: table of known one-dword CRCs plus stall, reset and random traffic.
module tb_sata_crc_inserter;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'h52325032;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_dat;
  logic        i_val, i_eop, i_rdy;
  logic [31:0] o_dat;
  logic        o_val, o_eop, o_rdy;

  sata_crc_inserter #(.CRC_INIT(SEED)) dut (
    .clk(clk), .reset(reset),
    .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] dat; logic eop; } beat_t;
  typedef struct { logic [31:0] dat; logic [31:0] crc; } vec_t;

  beat_t       exp_q[$];
  logic [31:0] frm[$];
  int n_checks = 0, n_fail = 0;
  int bubbles = 0, frames_done = 0, eop_seen = 0;
  int mode = 0, hold = 0;
  bit held = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-serial reference: one feedback decision per data bit, MSB first.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d);
    logic fb;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  // Downstream ready: 0 always ready, 1 random, 2 toggling with a 5-cycle hold on the CRC beat.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: o_rdy = 1'b1;
      1: o_rdy = 1'($urandom_range(1));
      default: begin
        if (hold > 0) begin
          o_rdy = 1'b0;
          hold--;
        end else if (o_val && o_eop && !held) begin
          held  = 1;
          hold  = 4;
          o_rdy = 1'b0;
        end else begin
          o_rdy = !o_rdy;
        end
        if (!o_eop) held = 0;
      end
    endcase
  end

  bit          prev_stall = 0;
  logic [33:0] prev_out;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_hold", 64'({o_val, o_eop, o_dat}), 64'(prev_out));
      if (o_val && o_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'({o_eop, o_dat}), 64'h0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_beat", 64'({o_eop, o_dat}), 64'({e.eop, e.dat}));
        end
        if (o_eop) eop_seen++;
      end
      prev_stall = o_val && !o_rdy;
      prev_out   = {o_val, o_eop, o_dat};
    end
  end

  task automatic send_frame(input int gap_pct, input int stop_after,
                            input bit use_exp, input logic [31:0] exp_crc);
    int k = 0, guard = 0;
    logic [31:0] c = SEED;
    while (k < frm.size() && (stop_after < 0 || k < stop_after)) begin
      @(posedge clk); #1;
      i_val = (int'($urandom_range(99)) >= gap_pct);
      i_dat = i_val ? frm[k] : $urandom;
      i_eop = i_val ? (k == frm.size() - 1) : 1'($urandom_range(1));
      @(negedge clk);
      if (i_val && i_rdy) begin
        exp_q.push_back('{dat: frm[k], eop: 1'b0});
        c = crc_ref(c, frm[k]);
        if (k == frm.size() - 1) begin
          exp_q.push_back('{dat: use_exp ? exp_crc : c, eop: 1'b1});
          frames_done++;
        end
        k++;
      end else if (i_val) begin
        bubbles++;
      end
      if (++guard > 5000) begin
        chk("send_timeout", 64'(k), 64'(frm.size()));
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    i_val = 1'b0;
    i_dat = $urandom;
    i_eop = 1'($urandom_range(1));
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic make_frame(input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back($urandom);
  endtask

  vec_t vecs[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Differences from the seed of 0,1,2,4 give x*x^32 mod P directly.
    vecs[0] = '{dat: 32'h52325032, crc: 32'h00000000};
    vecs[1] = '{dat: 32'h52325033, crc: 32'h04C11DB7};
    vecs[2] = '{dat: 32'h52325030, crc: 32'h09823B6E};
    vecs[3] = '{dat: 32'h52325036, crc: 32'h130476DC};

    reset = 1'b0; i_val = 1'b0; i_dat = '0; i_eop = 1'b0; o_rdy = 1'b1;
    #3;
    chk("reset_oval", 64'(o_val), 64'h0);
    chk("reset_odat", 64'(o_dat), 64'h0);
    chk("reset_oeop", 64'(o_eop), 64'h0);
    chk("reset_irdy", 64'(i_rdy), 64'h1);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // One-dword frames with hand-derived CRCs; i_rdy drops for exactly one cycle.
    for (int v = 0; v < 4; v++) begin
      frm.delete();
      frm.push_back(vecs[v].dat);
      send_frame(0, -1, 1, vecs[v].crc);
      idle();
      @(negedge clk); chk("bubble_low", 64'(i_rdy), 64'h0);
      @(negedge clk); chk("bubble_end", 64'(i_rdy), 64'h1);
      drain();
    end

    frm.delete();
    for (int i = 1; i <= 4; i++) frm.push_back(32'(i));
    send_frame(0, -1, 0, 0);
    drain();

    mode = 2;
    send_frame(0, -1, 0, 0);
    drain();
    chk("crc_hold_seen", 64'(held), 64'h1);
    mode = 0;

    // Back-to-back frames with i_val held high: one bubble per frame boundary.
    bubbles = 0;
    make_frame(1); send_frame(0, -1, 0, 0);
    make_frame(7); send_frame(0, -1, 0, 0);
    make_frame(2); send_frame(0, -1, 0, 0);
    drain();
    chk("b2b_bubbles", 64'(bubbles), 64'h2);

    // Reset mid-frame drops the partial frame and clears the output stage at once.
    make_frame(6);
    send_frame(0, 3, 0, 0);
    @(posedge clk); #2;
    chk("pre_reset_oval", 64'(o_val), 64'h1);
    reset = 1'b0; i_val = 1'b0;
    #1;
    chk("async_oval", 64'(o_val), 64'h0);
    chk("async_odat", 64'(o_dat), 64'h0);
    exp_q.delete();
    @(negedge clk);
    chk("reset_irdy_mid", 64'(i_rdy), 64'h1);
    reset = 1'b1;
    make_frame(2); send_frame(0, -1, 0, 0);
    drain();

    mode = 1;
    for (int f = 0; f < 1500; f++) begin
      make_frame(int'($urandom_range(1, 8)));
      send_frame(30, -1, 0, 0);
      if ($urandom_range(3) == 0) idle();
    end
    drain();
    chk("eop_count", 64'(eop_seen), 64'(frames_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
